// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM state
// encodings and the legal range of the WIDTH parameter.
package serial_adder_pkg;

    localparam int unsigned SA_STATE_W   = 2;
    localparam int unsigned SA_WIDTH_MIN = 2;
    localparam int unsigned SA_WIDTH_MAX = 32;

    typedef enum logic [SA_STATE_W-1:0] {
        SA_IDLE = 2'd0,
        SA_RUN  = 2'd1,
        SA_DONE = 2'd2
    } sa_state_e;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_fa.sv
// 1-bit combinational adder cells used by the serial adder.
//   ha: half adder   x, y      -> s, c
//   fa: full adder   x, y, ci  -> s, co  (two half adders plus an OR)

module ha (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule : ha

module fa (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    logic s0;
    logic c0;
    logic c1;

    ha u_ha0 (.x(x),  .y(y),  .s(s0), .c(c0));
    ha u_ha1 (.x(s0), .y(ci), .s(s),  .c(c1));

    // Both half-adder carries can never be high together, so OR suffices.
    assign co = c0 | c1;
endmodule : fa

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder/subtractor, LSB first, one full-adder slice
// with a registered carry. Subtraction adds ~b with carry-in 1.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   start          request, accepted in IDLE or DONE
//   sub            0 = a+b, 1 = a-b (latched with start)
//   a, b           operands (latched with start)
//   sum            result, registered, updates on completion only
//   carry          carry out (add) / not-borrow (sub), registered
//   overflow       signed overflow, registered
//   busy           high while a result is being computed
//   done           one-cycle pulse once the result is valid
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    generate
        if (WIDTH < SA_WIDTH_MIN || WIDTH > SA_WIDTH_MAX) begin : g_bad_width
            $error("serial_adder: WIDTH out of range");
        end
    endgenerate

    sa_state_e        state;
    sa_state_e        state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] res_nxt;
    logic [CNT_W-1:0] cnt;
    logic             c;
    logic             fa_s;
    logic             fa_co;
    logic             load;
    logic             shift;
    logic             finish;

    fa u_fa (
        .x  (a_sr[0]),
        .y  (b_sr[0]),
        .ci (c),
        .s  (fa_s),
        .co (fa_co)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= SA_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            SA_IDLE: if (start) state_nxt = SA_RUN;
            SA_RUN:  if (cnt == CNT_LAST) state_nxt = SA_DONE;
            SA_DONE: state_nxt = start ? SA_RUN : SA_IDLE;
            default: state_nxt = SA_IDLE;
        endcase
    end

    // Datapath controls decoded from the current state.
    always_comb begin
        load   = 1'b0;
        shift  = 1'b0;
        finish = 1'b0;
        unique case (state)
            SA_IDLE: load = start;
            SA_RUN: begin
                shift  = 1'b1;
                finish = (cnt == CNT_LAST);
            end
            SA_DONE: load = start;
            default: ;
        endcase
    end

    // New result bit enters at the MSB so the word is aligned after WIDTH shifts.
    assign res_nxt = {fa_s, res_sr[WIDTH-1:1]};

    // Datapath and registered outputs. busy/done are state decodes
    // delayed one cycle, so they appear once the result is stable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sr     <= '0;
            b_sr     <= '0;
            res_sr   <= '0;
            cnt      <= '0;
            c        <= 1'b0;
            sum      <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            busy <= (state == SA_RUN);
            done <= (state == SA_DONE);
            if (load) begin
                a_sr <= a;
                b_sr <= sub ? ~b : b;
                c    <= sub;
                cnt  <= '0;
            end else if (shift) begin
                a_sr   <= a_sr >> 1;
                b_sr   <= b_sr >> 1;
                res_sr <= res_nxt;
                c      <= fa_co;
                cnt    <= cnt + CNT_W'(1);
            end
            if (finish) begin
                sum      <= res_nxt;
                carry    <= fa_co;
                overflow <= c ^ fa_co;
            end
        end
    end

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8 and WIDTH=16 instances)
// against an arithmetic reference model.
module tb_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start8, sub8, carry8, ovf8, busy8, done8;
    logic [7:0]  a8, b8, sum8;
    logic        start16, sub16, carry16, ovf16, busy16, done16;
    logic [15:0] a16, b16, sum16;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8),
        .sum(sum8), .carry(carry8), .overflow(ovf8), .busy(busy8), .done(done8)
    );

    serial_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .sub(sub16), .a(a16), .b(b16),
        .sum(sum16), .carry(carry16), .overflow(ovf16), .busy(busy16), .done(done16)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Returns {overflow, carry, sum} from plain integer arithmetic.
    function automatic logic [33:0] ref_op(input int w, input logic [31:0] a,
                                           input logic [31:0] b, input logic sub);
        longint lim, modv, ua, ub, sa, sb, ru, rs;
        logic   cy, ov;
        lim  = longint'(1) << (w - 1);
        modv = lim * 2;
        ua   = longint'(a) & (modv - 1);
        ub   = longint'(b) & (modv - 1);
        sa   = (ua >= lim) ? ua - modv : ua;
        sb   = (ub >= lim) ? ub - modv : ub;
        if (!sub) begin
            ru = ua + ub;
            cy = (ru >= modv);
            rs = sa + sb;
        end else begin
            ru = ua - ub;
            cy = (ua >= ub);
            rs = sa - sb;
        end
        ov = (rs >= lim) || (rs < -lim);
        return {ov, cy, 32'(ru & (modv - 1))};
    endfunction

    task automatic drive(input int w, input logic [31:0] a, input logic [31:0] b,
                         input logic sub, input logic st);
        if (w == 8) begin
            a8 = a[7:0]; b8 = b[7:0]; sub8 = sub; start8 = st;
        end else begin
            a16 = a[15:0]; b16 = b[15:0]; sub16 = sub; start16 = st;
        end
    endtask

    task automatic sample(input int w, output logic [31:0] s, output logic cy,
                          output logic ov, output logic bz, output logic dn);
        if (w == 8) begin
            s = 32'(sum8); cy = carry8; ov = ovf8; bz = busy8; dn = done8;
        end else begin
            s = 32'(sum16); cy = carry16; ov = ovf16; bz = busy16; dn = done16;
        end
    endtask

    // One operation: latency, busy length, result, single-cycle done.
    task automatic do_op(input int w, input logic [31:0] a, input logic [31:0] b,
                         input logic sub, input logic [33:0] e, input string tag);
        logic [31:0] s;
        logic        cy, ov, bz, dn;
        int          n_lat = 0;
        int          n_busy = 0;
        bit          seen = 0;
        drive(w, a, b, sub, 1'b1);
        @(posedge clk); #1;
        drive(w, $urandom, $urandom, 1'($urandom), 1'b0);
        for (int i = 1; i <= w + 4 && !seen; i++) begin
            @(posedge clk); #1;
            sample(w, s, cy, ov, bz, dn);
            if (bz) n_busy++;
            if (dn) begin
                seen  = 1;
                n_lat = i;
            end else begin
                drive(w, $urandom, $urandom, 1'($urandom), 1'b0);
            end
        end
        check({tag, "_latency"}, 32'(n_lat), 32'(w + 1));
        check({tag, "_busy_cycles"}, 32'(n_busy), 32'(w));
        check({tag, "_busy_in_done"}, 32'(bz), 32'd0);
        check({tag, "_sum"}, s, e[31:0]);
        check({tag, "_carry"}, 32'(cy), 32'(e[32]));
        check({tag, "_overflow"}, 32'(ov), 32'(e[33]));
        @(posedge clk); #1;
        sample(w, s, cy, ov, bz, dn);
        check({tag, "_done_pulse"}, 32'(dn), 32'd0);
        check({tag, "_sum_hold"}, s, e[31:0]);
    endtask

    logic [33:0] expq[$];

    initial begin
        logic [31:0] s, ra, rb;
        logic        cy, ov, bz, dn, rsub;
        logic [33:0] e;

        rst_n = 1'b0;
        drive(8, 0, 0, 1'b0, 1'b0);
        drive(16, 0, 0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        sample(8, s, cy, ov, bz, dn);
        check("rst_sum", s, 32'd0);
        check("rst_carry", 32'(cy), 32'd0);
        check("rst_ovf", 32'(ov), 32'd0);
        check("rst_busy", 32'(bz), 32'd0);
        check("rst_done", 32'(dn), 32'd0);
        sample(16, s, cy, ov, bz, dn);
        check("rst16_busy_done", 32'({bz, dn}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors with hand-computed expectations {ovf, carry, sum}.
        do_op(8, 32'h0F, 32'h01, 1'b0, {1'b0, 1'b0, 32'h10}, "add_0f_01");
        do_op(8, 32'hFF, 32'h01, 1'b0, {1'b0, 1'b1, 32'h00}, "add_ff_01");
        do_op(8, 32'h7F, 32'h01, 1'b0, {1'b1, 1'b0, 32'h80}, "add_7f_01");
        do_op(8, 32'h05, 32'h07, 1'b1, {1'b0, 1'b0, 32'hFE}, "sub_05_07");
        do_op(8, 32'h80, 32'h01, 1'b1, {1'b1, 1'b1, 32'h7F}, "sub_80_01");
        do_op(8, 32'h00, 32'h00, 1'b1, {1'b0, 1'b1, 32'h00}, "sub_00_00");
        do_op(16, 32'hFFFF, 32'hFFFF, 1'b0, {1'b0, 1'b1, 32'hFFFE}, "add16_ffff");

        // Randomized operations against the reference model.
        for (int i = 0; i < 16; i++) begin
            ra = $urandom; rb = $urandom; rsub = 1'($urandom);
            do_op(8, ra, rb, rsub, ref_op(8, ra, rb, rsub), $sformatf("rnd8_%0d", i));
        end
        for (int i = 0; i < 6; i++) begin
            ra = $urandom; rb = $urandom; rsub = 1'($urandom);
            do_op(16, ra, rb, rsub, ref_op(16, ra, rb, rsub), $sformatf("rnd16_%0d", i));
        end

        // Back-to-back: start held high, operands change every cycle; a new
        // operation is accepted every 9 edges from the first acceptance.
        repeat (2) @(posedge clk);
        #1;
        for (int t = 0; t <= 36; t++) begin
            ra = $urandom; rb = $urandom; rsub = 1'($urandom);
            drive(8, ra, rb, rsub, 1'b1);
            if (t % 9 == 0) expq.push_back(ref_op(8, ra, rb, rsub));
            @(posedge clk); #1;
            sample(8, s, cy, ov, bz, dn);
            if (t > 0 && t % 9 == 0) begin
                check($sformatf("b2b_done_t%0d", t), 32'(dn), 32'd1);
                e = expq.pop_front();
                check($sformatf("b2b_sum_t%0d", t), s, e[31:0]);
                check($sformatf("b2b_cy_ov_t%0d", t), 32'({ov, cy}), 32'(e[33:32]));
            end else if (t > 0) begin
                check($sformatf("b2b_nodone_t%0d", t), 32'(dn), 32'd0);
            end
        end
        drive(8, 0, 0, 1'b0, 1'b0);
        repeat (12) @(posedge clk);
        #1;

        // Reset in the middle of a run (during bit 4).
        drive(8, 32'h55, 32'h22, 1'b0, 1'b1);
        @(posedge clk); #1;
        drive(8, 0, 0, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        sample(8, s, cy, ov, bz, dn);
        check("midrst_sum", s, 32'd0);
        check("midrst_flags", 32'({cy, ov, bz, dn}), 32'd0);
        @(posedge clk); #1;
        sample(8, s, cy, ov, bz, dn);
        check("midrst_idle", 32'({bz, dn}), 32'd0);
        do_op(8, 32'h03, 32'h04, 1'b0, {1'b0, 1'b0, 32'h07}, "post_rst_add");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_serial_adder

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial WIDTH-bit adder/subtractor: processes one bit per clock, LSB first, through a single full-adder slice with a registered carry.
- Generalises the switch-driven 1-bit half adder to parametrised width, adds a subtract mode, signed overflow and a start/done handshake.
- Sits between the switch/LED top level (operands from SW, results to LEDR) and any later controller that needs a small-area adder.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  synchronous reset, active low.
- start  input  1  request; sampled only in IDLE or DONE.
- sub  input  1  0 = a+b, 1 = a-b; latched with start.
- a  input  WIDTH  operand A; latched with start.
- b  input  WIDTH  operand B; latched with start.
- sum  output  WIDTH  result, registered.
- carry  output  1  carry out (add) or NOT borrow (sub), registered.
- overflow  output  1  two's-complement signed overflow, registered.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when the result becomes valid.

Behaviour:
- Reset: rst_n low at a rising edge forces state IDLE and clears sum, carry, overflow, busy, done and all internal registers to 0. This applies in any state, including mid-RUN; any partial result is discarded.
- FSM has three states: IDLE, RUN, DONE.
- IDLE: start=1 latches a into shift register A and latches b, or ~b when sub=1, into shift register B. It loads carry register c = sub and bit counter = 0, then moves to RUN. start=0 holds IDLE.
- RUN: busy=1. Each cycle the full-adder slice takes A[0], B[0] and c. Its sum bit shifts into the MSB of the result shift register, and c takes the slice carry. A and B shift right and the counter increments.
- RUN ends when the counter reaches WIDTH-1. After that WIDTH-th bit cycle, the state moves to DONE.
- On the final bit, overflow = c_in XOR c_out of the MSB slice. The carry output takes the final c.
- sum, carry and overflow update only on the RUN→DONE transition. They hold stable at all other times, including during a following RUN.
- DONE: done=1 and busy=0 for exactly one cycle.
  - start=1 in DONE is accepted exactly as in IDLE (back-to-back operation, goes straight to RUN).
  - Otherwise the next state is IDLE.
- Latency: with start sampled at edge k, done is high in the cycle between edges k+WIDTH+1 and k+WIDTH+2 (WIDTH+1 cycles after acceptance). Throughput is one result per WIDTH+1 cycles.
- start=1 during RUN is ignored; operands and mode are unaffected.
- Changes to a, b or sub after acceptance have no effect.
- Arithmetic is modulo 2^WIDTH.
  - Add: carry = bit WIDTH of a+b.
  - Sub: carry = 1 when a >= b (unsigned), 0 on borrow.
- busy and done are never high simultaneously.

Decomposition:
- Shared package/include holds the state encodings SA_IDLE=2'd0, SA_RUN=2'd1, SA_DONE=2'd2 and the WIDTH legal-range check constants.
- Sub-module fa: 1-bit combinational full adder built from two ha instances plus an OR gate, reusing the existing half-adder module.
- serial_adder instantiates exactly one fa.
- Top-level wiring is out of scope for this block:
  - SW[7:0]/SW[8] drive a and sub.
  - a KEY pulse drives start.
  - LEDR shows sum, carry and overflow.

Test Plan:
- WIDTH=8, add 8'h0F+8'h01 → sum=8'h10, carry=0, overflow=0; done pulses once, 9 cycles after start is sampled; busy high for exactly 8 cycles.
- Add 8'hFF+8'h01 → sum=8'h00, carry=1, overflow=0. Add 8'h7F+8'h01 → sum=8'h80, carry=0, overflow=1.
- Sub 8'h05-8'h07 → sum=8'hFE, carry=0, overflow=0. Sub 8'h80-8'h01 → sum=8'h7F, carry=1, overflow=1.
- Hold start=1 continuously with a/b changing during RUN → each result reflects only the operands latched at acceptance; the next op starts from DONE, giving done every 9 cycles.
- Assert rst_n=0 for one cycle at RUN bit 4 → next cycle: busy=0, done=0, sum=0, carry=0, overflow=0, state IDLE. A new start 8'h03+8'h04 then gives sum=8'h07.
- WIDTH=16 instance: add 16'hFFFF+16'hFFFF → sum=16'hFFFE, carry=1, overflow=0, done 17 cycles after start.
